// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES-128 input stage.
//   AES_BLK_W / AES_WORD_W : default block and input-word widths
//   fsm_e                  : loader state (COLLECT / HOLD)
//   SEL_DATA / SEL_KEY     : encodings of the word-channel select
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_BLK_W  = 128;
    localparam int unsigned AES_WORD_W = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } fsm_e;

    localparam logic SEL_DATA = 1'b0;
    localparam logic SEL_KEY  = 1'b1;

endpackage

// File: rtl/aes_word_packer.sv
// ----------------------------------------------------------------------------
// aes_word_packer
// Packs a stream of WORD_W words into a DATA_W shadow, first word at the MSBs.
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_flush          : restart the group (counter to 0)
//   i_wr_en          : accept i_word this cycle
//   i_word           : input word
//   o_merged_c       : shadow with the current word already merged in
//   o_done_c         : i_wr_en on the last word of a group
// ----------------------------------------------------------------------------
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W = AES_BLK_W,
    parameter int unsigned WORD_W = AES_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_word,
    output logic [DATA_W-1:0] o_merged_c,
    output logic              o_done_c
);

    localparam int unsigned N     = DATA_W / WORD_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] w_merged;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_done;

    // Overlay the incoming word onto the slice selected by the counter
    always_comb begin
        w_merged = r_shadow;
        for (int unsigned k = 0; k < N; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_merged[DATA_W-1-k*WORD_W -: WORD_W] = i_word;
            end
        end
    end

    assign w_done     = i_wr_en && (r_cnt == LAST);
    assign o_merged_c = w_merged;
    assign o_done_c   = w_done;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_shadow <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_cnt    <= '0;
        end else if (i_wr_en) begin
            r_shadow <= w_merged;
            r_cnt    <= w_done ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// ----------------------------------------------------------------------------
// aes_block_loader
// Assembles a word stream into a cipher key and a data block for the AES core.
// Ports:
//   clk_i, reset_n_i          : clock, synchronous active-low reset
//   in_valid_i/in_ready_o     : word handshake; in_sel_i picks data(0)/key(1)
//   in_data_i, enc_or_dec_i   : word payload, mode (taken with last data word)
//   flush_i                   : drop partial assembly and any held block
//   key_o, key_load_o         : current key and one-cycle "new key" pulse
//   key_ready_i               : key expansion done with current key
//   blk_valid_o/blk_ready_i   : block handshake to the round datapath
//   state_o, enc_or_dec_o     : held data block and its mode
// ----------------------------------------------------------------------------
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int unsigned DATA_W = AES_BLK_W,
    parameter int unsigned WORD_W = AES_WORD_W
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_sel_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              enc_or_dec_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] key_o,
    output logic              key_load_o,
    input  logic              key_ready_i,
    output logic              blk_valid_o,
    input  logic              blk_ready_i,
    output logic [DATA_W-1:0] state_o,
    output logic              enc_or_dec_o
);

    fsm_e              r_fsm;
    fsm_e              w_fsm_nxt;

    logic              r_in_ready;
    logic              r_key_valid;
    logic              r_key_load;
    logic              r_blk_valid;
    logic              r_enc;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_state;

    logic              w_word_acc;
    logic              w_data_wr;
    logic              w_key_wr;
    logic              w_data_done;
    logic              w_key_done;
    logic              w_blk_acc;
    logic [DATA_W-1:0] w_data_merged;
    logic [DATA_W-1:0] w_key_merged;

    logic              w_key_valid_nxt;
    logic              w_blk_valid_nxt;
    logic              w_in_ready_nxt;

    // Flush blocks any word presented in the same cycle
    assign w_word_acc = in_valid_i && r_in_ready && !flush_i;
    // Data words taken while holding (only possible with no key) are dropped
    assign w_data_wr  = w_word_acc && (in_sel_i == SEL_DATA) && (r_fsm == COLLECT);
    assign w_key_wr   = w_word_acc && (in_sel_i == SEL_KEY);
    assign w_blk_acc  = r_blk_valid && blk_ready_i;

    aes_word_packer #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_data_packer (
        .i_clk      (clk_i),
        .i_reset_n  (reset_n_i),
        .i_flush    (flush_i),
        .i_wr_en    (w_data_wr),
        .i_word     (in_data_i),
        .o_merged_c (w_data_merged),
        .o_done_c   (w_data_done)
    );

    aes_word_packer #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_key_packer (
        .i_clk      (clk_i),
        .i_reset_n  (reset_n_i),
        .i_flush    (flush_i),
        .i_wr_en    (w_key_wr),
        .i_word     (in_data_i),
        .o_merged_c (w_key_merged),
        .o_done_c   (w_key_done)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_fsm <= COLLECT;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next state
    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            COLLECT: begin
                if (!flush_i && w_data_done) begin
                    w_fsm_nxt = HOLD;
                end
            end
            HOLD: begin
                if (flush_i || w_blk_acc) begin
                    w_fsm_nxt = COLLECT;
                end
            end
            default: w_fsm_nxt = COLLECT;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_key_valid_nxt = r_key_valid || w_key_done;
        // Once raised, blk_valid sticks until the block leaves HOLD; a fresh
        // key keeps it low through the load pulse cycle and the one after.
        w_blk_valid_nxt = (w_fsm_nxt == HOLD) &&
                          (r_blk_valid ||
                           (w_key_valid_nxt && key_ready_i && !r_key_load && !w_key_done));
        w_in_ready_nxt  = (w_fsm_nxt == COLLECT) || !w_key_valid_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_in_ready  <= 1'b0;
            r_key_valid <= 1'b0;
            r_key_load  <= 1'b0;
            r_blk_valid <= 1'b0;
            r_enc       <= 1'b0;
            r_key       <= '0;
            r_state     <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_load  <= w_key_done;
            r_blk_valid <= w_blk_valid_nxt;
            if (w_key_done) begin
                r_key <= w_key_merged;
            end
            if (w_data_done) begin
                r_state <= w_data_merged;
                r_enc   <= enc_or_dec_i;
            end
        end
    end

    assign in_ready_o   = r_in_ready;
    assign key_o        = r_key;
    assign key_load_o   = r_key_load;
    assign blk_valid_o  = r_blk_valid;
    assign state_o      = r_state;
    assign enc_or_dec_o = r_enc;

endmodule

// File: tb/tb_aes_block_loader.sv
// ----------------------------------------------------------------------------
// tb_aes_block_loader
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based reference model of the loader.
// ----------------------------------------------------------------------------
module tb_aes_block_loader;

    localparam int unsigned DW = 128;
    localparam int unsigned WW = 32;
    localparam int unsigned N  = DW / WW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sel;
    logic [WW-1:0] in_data;
    logic          enc_in;
    logic          flush;
    logic [DW-1:0] key;
    logic          key_load;
    logic          key_ready;
    logic          blk_valid;
    logic          blk_ready;
    logic [DW-1:0] state;
    logic          enc_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_block_loader #(
        .DATA_W (DW),
        .WORD_W (WW)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_sel_i     (in_sel),
        .in_data_i    (in_data),
        .enc_or_dec_i (enc_in),
        .flush_i      (flush),
        .key_o        (key),
        .key_load_o   (key_load),
        .key_ready_i  (key_ready),
        .blk_valid_o  (blk_valid),
        .blk_ready_i  (blk_ready),
        .state_o      (state),
        .enc_or_dec_o (enc_out)
    );

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_in_ready, m_kv, m_load, m_bv, m_enc, m_hold;
    logic [DW-1:0] m_key, m_state;
    logic [WW-1:0] dq[$];
    logic [WW-1:0] kq[$];

    function automatic logic [DW-1:0] pack(input logic [WW-1:0] q[$]);
        logic [DW-1:0] v = '0;
        foreach (q[i]) v = (v << WW) | DW'(q[i]);
        return v;
    endfunction

    task automatic model_step();
        bit acc, bacc, newload, prev_bv, prev_load, was_hold;
        if (!reset_n) begin
            m_in_ready = 0; m_kv = 0; m_load = 0; m_bv = 0; m_enc = 0; m_hold = 0;
            m_key = '0; m_state = '0;
            dq.delete(); kq.delete();
            return;
        end
        acc       = in_valid && m_in_ready && !flush;
        bacc      = m_bv && blk_ready;
        prev_bv   = m_bv;
        prev_load = m_load;
        was_hold  = m_hold;
        newload   = 0;
        if (flush) begin
            dq.delete(); kq.delete();
            m_hold = 0;
        end else begin
            if (acc && in_sel) begin
                kq.push_back(in_data);
                if (kq.size() == N) begin
                    m_key = pack(kq); kq.delete(); m_kv = 1; newload = 1;
                end
            end
            if (acc && !in_sel && !was_hold) begin
                dq.push_back(in_data);
                if (dq.size() == N) begin
                    m_state = pack(dq); m_enc = enc_in; dq.delete(); m_hold = 1;
                end
            end
            if (bacc) m_hold = 0;
        end
        m_bv       = m_hold && (prev_bv || (m_kv && key_ready && !prev_load && !newload));
        m_load     = newload;
        m_in_ready = !m_hold || !m_kv;
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk1("in_ready", in_ready, m_in_ready);
            chk1("key_load", key_load, m_load);
            chk1("blk_valid", blk_valid, m_bv);
            chk1("enc_or_dec", enc_out, m_enc);
            chkw("key_o", key, m_key);
            chkw("state_o", state, m_state);
        end
    end

    // Key-expansion stand-in: busy for a few cycles after each key load
    initial begin
        int wait_c = 0;
        key_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                key_ready = 1'b0; wait_c = 0;
            end else if (key_load) begin
                key_ready = 1'b0; wait_c = int'($urandom_range(1, 4));
            end else if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 0) key_ready = 1'b1;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance
    task automatic send_word(input bit sel, input logic [WW-1:0] w, input bit enc);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout @%0t: in_ready stuck at %b, want 1", $time, in_ready);
        end
        in_valid = 1'b1; in_sel = sel; in_data = w; enc_in = enc;
        @(negedge clk);
        in_valid = 1'b0; enc_in = 1'b0;
    endtask

    task automatic wait_blk_valid(input string name);
        int t = 0;
        while (!blk_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk1(name, blk_valid, 1'b1);
    endtask

    task automatic wait_key_ready();
        int t = 0;
        while (!key_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk1("key_ready_wait", key_ready, 1'b1);
    endtask

    logic [WW-1:0] kw1[4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    logic [WW-1:0] dw1[4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    logic [WW-1:0] dw2[4] = '{32'hdeadbeef, 32'hcafef00d, 32'h01234567, 32'h89abcdef};
    logic [WW-1:0] dw3[4] = '{32'h11223344, 32'h55667788, 32'h99aabbcc, 32'hddeeff00};
    logic [WW-1:0] kw2[4] = '{32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};
    logic [WW-1:0] dw4[4] = '{32'ha0a1a2a3, 32'ha4a5a6a7, 32'ha8a9aaab, 32'hacadaeaf};

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        enc_in = 1'b0; flush = 1'b0; blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_blk_valid", blk_valid, 1'b0);
        chkw("rst_key", key, '0);
        chkw("rst_state", state, '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // Key load
        for (int i = 0; i < 4; i++) send_word(1'b1, kw1[i], 1'b0);
        chk1("key_load_pulse", key_load, 1'b1);
        chkw("key_value", key, 128'h000102030405060708090a0b0c0d0e0f);
        @(negedge clk);
        chk1("key_load_drop", key_load, 1'b0);
        wait_key_ready();

        // Block with immediate acceptance
        blk_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(1'b0, dw1[i], i == 3);
        chk1("blk_valid_latency", blk_valid, 1'b1);
        chkw("state_value", state, 128'h00112233445566778899aabbccddeeff);
        chk1("enc_value", enc_out, 1'b1);
        chk1("hold_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk1("accepted_blk_valid", blk_valid, 1'b0);
        chk1("accepted_in_ready", in_ready, 1'b1);

        // Backpressure in HOLD
        blk_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(1'b0, dw2[i], 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_blk_valid", blk_valid, 1'b1);
            chkw("bp_state", state, 128'hdeadbeefcafef00d0123456789abcdef);
            @(negedge clk);
        end
        blk_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release", blk_valid, 1'b0);
        chk1("bp_in_ready_back", in_ready, 1'b1);

        // Data before key after reset
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_word(1'b0, dw3[i], 1'b0);
        chk1("nokey_in_ready", in_ready, 1'b1);
        chk1("nokey_blk_valid", blk_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk1("nokey_key_in_ready", in_ready, 1'b1);
            send_word(1'b1, kw2[i], 1'b0);
        end
        chk1("late_key_load", key_load, 1'b1);
        chk1("late_key_blk_valid", blk_valid, 1'b0);
        wait_blk_valid("late_key_release");
        chkw("late_key_state", state, 128'h112233445566778899aabbccddeeff00);
        @(negedge clk);

        // Flush mid-assembly
        blk_ready = 1'b0;
        send_word(1'b0, 32'h55555555, 1'b0);
        send_word(1'b0, 32'h66666666, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h77777777;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send_word(1'b0, dw4[i], 1'b0);
        chkw("flush_state", state, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);
        chkw("flush_key_kept", key, 128'h101112131415161718191a1b1c1d1e1f);
        wait_blk_valid("flush_block_valid");

        // Reset during HOLD
        reset_n = 1'b0;
        @(negedge clk);
        chk1("rst_hold_blk_valid", blk_valid, 1'b0);
        chkw("rst_hold_key", key, '0);
        chkw("rst_hold_state", state, '0);
        chk1("rst_hold_in_ready", in_ready, 1'b0);
        reset_n = 1'b1; blk_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("rst_hold_no_emit", blk_valid, 1'b0);
        end

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = ($urandom_range(0, 2) == 0);
            in_data   = $urandom;
            enc_in    = $urandom_range(0, 1) == 1;
            flush     = ($urandom_range(0, 39) == 0);
            blk_ready = ($urandom_range(0, 2) != 0);
            reset_n   = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
